// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch/jump flush stretching,
// cache-switch freeze sequencing and saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_CYCLES     = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_busywait,
  input  logic             d_busywait,
  input  logic             ex_d_mem_r,
  input  logic             ex_write_reg_en,
  input  logic [4:0]       ex_write_address,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             branch_jump_signal,
  input  logic             switch_cache_req,
  input  logic             switch_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic             pipe_busywait,
  output logic             switch_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MAX_HOLD = (LOAD_USE_BUBBLES > FLUSH_CYCLES) ? LOAD_USE_BUBBLES : FLUSH_CYCLES;
  localparam int CW       = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH_HOLD, SWITCH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             flush_start;
  logic             stall_event;

  assign hz = ex_d_mem_r & ex_write_reg_en & (ex_write_address != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_write_address)) |
               (id_use_rs2 & (id_rs2 == ex_write_address)));

  // Gated by reset so every control output is low for the whole reset window.
  assign pipe_busywait = !reset & (i_busywait | d_busywait | (state_q == SWITCH));

  // NOTE: all state uses non-blocking assignments and an async clear; the
  // combinational blocks below compute only the _d values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // NOTE: every variable gets a default first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_start = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_jump_signal) begin
          flush_start = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH_HOLD;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
          end
        end else if (hz && !pipe_busywait) begin
          if (LOAD_USE_BUBBLES > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = CW'(LOAD_USE_BUBBLES - 1);
          end
        end else if (switch_cache_req && !pipe_busywait) begin
          state_d = SWITCH;
        end
      end
      LOAD_STALL: begin
        if (branch_jump_signal) begin
          flush_start = 1'b1;
          state_d     = (FLUSH_CYCLES > 1) ? FLUSH_HOLD : RUN;
          cnt_d       = CW'(FLUSH_CYCLES - 1);
        end else if (!pipe_busywait) begin
          if (cnt_q <= CW'(1)) state_d = RUN;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      FLUSH_HOLD: begin
        if (branch_jump_signal) begin
          flush_start = 1'b1;
          cnt_d       = CW'(FLUSH_CYCLES - 1);
        end else if (!pipe_busywait) begin
          if (cnt_q <= CW'(1)) state_d = RUN;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      SWITCH: begin
        if (switch_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    flush         = 1'b0;
    switch_active = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (branch_jump_signal) begin
            flush = 1'b1;
          end else if (hz && !pipe_busywait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (branch_jump_signal) begin
            flush = 1'b1;
          end else begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        FLUSH_HOLD: flush         = 1'b1;
        SWITCH:     switch_active = 1'b1;
        default:    flush         = 1'b0;
      endcase
    end
  end

  assign stall_event = pc_stall | pipe_busywait;

  assign stall_cnt_d = (stall_event && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_start && !reset && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1)
                                                                       : flush_cnt_q;

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (single-cycle and stretched bubble/flush)
// share stimulus; per-cycle expectations flow through a scoreboard queue.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_busywait, d_busywait, ex_d_mem_r, ex_write_reg_en;
  logic [4:0] ex_write_address, id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2, branch_jump_signal, switch_cache_req, switch_done;

  logic       pc_stall_a, if_id_stall_a, id_ex_bubble_a, flush_a, pipe_busywait_a, switch_active_a;
  logic       pc_stall_b, if_id_stall_b, id_ex_bubble_b, flush_b, pipe_busywait_b, switch_active_b;
  logic [3:0] stall_count_a, flush_count_a, stall_count_b, flush_count_b;
  logic [5:0] o_a, o_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ib, db, mr, we;
    logic [4:0] wa, rs1, rs2;
    logic       u1, u2, bj, sreq, sdone;
  } stim_t;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .i_busywait(i_busywait), .d_busywait(d_busywait),
    .ex_d_mem_r(ex_d_mem_r), .ex_write_reg_en(ex_write_reg_en), .ex_write_address(ex_write_address),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .branch_jump_signal(branch_jump_signal), .switch_cache_req(switch_cache_req),
    .switch_done(switch_done), .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a),
    .id_ex_bubble(id_ex_bubble_a), .flush(flush_a), .pipe_busywait(pipe_busywait_a),
    .switch_active(switch_active_a), .stall_count(stall_count_a), .flush_count(flush_count_a)
  );

  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(2), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .i_busywait(i_busywait), .d_busywait(d_busywait),
    .ex_d_mem_r(ex_d_mem_r), .ex_write_reg_en(ex_write_reg_en), .ex_write_address(ex_write_address),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .branch_jump_signal(branch_jump_signal), .switch_cache_req(switch_cache_req),
    .switch_done(switch_done), .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b),
    .id_ex_bubble(id_ex_bubble_b), .flush(flush_b), .pipe_busywait(pipe_busywait_b),
    .switch_active(switch_active_b), .stall_count(stall_count_b), .flush_count(flush_count_b)
  );

  // Bit order: pc_stall, if_id_stall, id_ex_bubble, flush, pipe_busywait, switch_active
  assign o_a = {pc_stall_a, if_id_stall_a, id_ex_bubble_a, flush_a, pipe_busywait_a, switch_active_a};
  assign o_b = {pc_stall_b, if_id_stall_b, id_ex_bubble_b, flush_b, pipe_busywait_b, switch_active_b};

  // hz=1 builds a load to x5 in EX with the ID instruction reading x5 through rs1.
  function automatic stim_t mk(input bit ib, input bit db, input bit hz, input bit bj,
                               input bit sreq, input bit sdone);
    stim_t s;
    s.ib = ib;  s.db = db;  s.mr = hz;  s.we = 1'b1;
    s.wa = 5'd5; s.rs1 = 5'd5; s.rs2 = 5'd7;
    s.u1 = 1'b1; s.u2 = 1'b1;
    s.bj = bj;  s.sreq = sreq; s.sdone = sdone;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    i_busywait = s.ib; d_busywait = s.db; ex_d_mem_r = s.mr; ex_write_reg_en = s.we;
    ex_write_address = s.wa; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; branch_jump_signal = s.bj;
    switch_cache_req = s.sreq; switch_done = s.sdone;
  endtask

  task automatic do_reset();
    apply(mk(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(mk(1, 1, 1, 1, 1, 1));
    #2;
    checks++;
    if (o_a !== 6'b0 || o_b !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs a=%b b=%b expected 000000", o_a, o_b);
    end
    checks++;
    if (stall_count_a !== 4'd0 || flush_count_a !== 4'd0 || stall_count_b !== 4'd0 || flush_count_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters a=%0d/%0d b=%0d/%0d expected 0", stall_count_a, flush_count_a,
               stall_count_b, flush_count_b);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    do_reset();
    st.push_back(mk(0, 0, 1, 0, 0, 0)); ex.push_back('{6'b111000, 6'b111000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b111000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (o_a !== e.a) begin errors++; $display("FAIL load_use[%0d] dut_a got %b expected %b", i, o_a, e.a); end
      checks++;
      if (o_b !== e.b) begin errors++; $display("FAIL load_use[%0d] dut_b got %b expected %b", i, o_b, e.b); end
    end
    checks++;
    if (stall_count_a !== 4'd1 || stall_count_b !== 4'd2) begin
      errors++;
      $display("FAIL load_use_stall_count a=%0d b=%0d expected 1/2", stall_count_a, stall_count_b);
    end
  endtask

  task automatic test_no_hazard();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    stim_t s;
    do_reset();
    s = mk(0, 0, 1, 0, 0, 0); s.wa = 5'd0; s.rs1 = 5'd0;          // load writes x0
    st.push_back(s); ex.push_back('{6'b000000, 6'b000000});
    s = mk(0, 0, 1, 0, 0, 0); s.we = 1'b0;                         // no register write
    st.push_back(s); ex.push_back('{6'b000000, 6'b000000});
    s = mk(0, 0, 0, 0, 0, 0);                                      // ALU op, rd matches
    st.push_back(s); ex.push_back('{6'b000000, 6'b000000});
    s = mk(0, 0, 1, 0, 0, 0); s.rs1 = 5'd3; s.rs2 = 5'd5; s.u2 = 1'b0; // rs2 match, unused
    st.push_back(s); ex.push_back('{6'b000000, 6'b000000});
    s.u2 = 1'b1;                                                   // rs2 match, used
    st.push_back(s); ex.push_back('{6'b111000, 6'b111000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b111000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (o_a !== e.a) begin errors++; $display("FAIL no_hazard[%0d] dut_a got %b expected %b", i, o_a, e.a); end
      checks++;
      if (o_b !== e.b) begin errors++; $display("FAIL no_hazard[%0d] dut_b got %b expected %b", i, o_b, e.b); end
    end
    checks++;
    if (stall_count_a !== 4'd1 || stall_count_b !== 4'd2) begin
      errors++;
      $display("FAIL no_hazard_stall_count a=%0d b=%0d expected 1/2", stall_count_a, stall_count_b);
    end
  endtask

  task automatic test_flush();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    do_reset();
    st.push_back(mk(0, 0, 1, 1, 0, 0)); ex.push_back('{6'b000100, 6'b000100});
    st.push_back(mk(0, 0, 1, 0, 0, 0)); ex.push_back('{6'b111000, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    st.push_back(mk(0, 0, 0, 1, 0, 0)); ex.push_back('{6'b000100, 6'b000100});
    st.push_back(mk(0, 0, 0, 1, 0, 0)); ex.push_back('{6'b000100, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    st.push_back(mk(0, 1, 0, 1, 0, 0)); ex.push_back('{6'b000110, 6'b000110});
    st.push_back(mk(0, 1, 0, 0, 0, 0)); ex.push_back('{6'b000010, 6'b000110});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000100});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (o_a !== e.a) begin errors++; $display("FAIL flush[%0d] dut_a got %b expected %b", i, o_a, e.a); end
      checks++;
      if (o_b !== e.b) begin errors++; $display("FAIL flush[%0d] dut_b got %b expected %b", i, o_b, e.b); end
    end
    checks++;
    if (flush_count_a !== 4'd4 || flush_count_b !== 4'd4) begin
      errors++;
      $display("FAIL flush_count a=%0d b=%0d expected 4/4", flush_count_a, flush_count_b);
    end
    checks++;
    if (stall_count_a !== 4'd3 || stall_count_b !== 4'd2) begin
      errors++;
      $display("FAIL flush_stall_count a=%0d b=%0d expected 3/2", stall_count_a, stall_count_b);
    end
  endtask

  task automatic test_busywait_load();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      st.push_back(mk(0, 1, 1, 0, 0, 0)); ex.push_back('{6'b000010, 6'b000010});
    end
    st.push_back(mk(0, 0, 1, 0, 0, 0)); ex.push_back('{6'b111000, 6'b111000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b111000});
    st.push_back(mk(0, 0, 1, 0, 0, 0)); ex.push_back('{6'b111000, 6'b111000});
    st.push_back(mk(0, 1, 0, 0, 0, 0)); ex.push_back('{6'b000010, 6'b111010});
    st.push_back(mk(1, 0, 0, 0, 0, 0)); ex.push_back('{6'b000010, 6'b111010});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b111000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (o_a !== e.a) begin errors++; $display("FAIL busywait_load[%0d] dut_a got %b expected %b", i, o_a, e.a); end
      checks++;
      if (o_b !== e.b) begin errors++; $display("FAIL busywait_load[%0d] dut_b got %b expected %b", i, o_b, e.b); end
    end
    checks++;
    if (stall_count_a !== 4'd8 || stall_count_b !== 4'd10) begin
      errors++;
      $display("FAIL busywait_stall_count a=%0d b=%0d expected 8/10", stall_count_a, stall_count_b);
    end
  endtask

  task automatic test_switch();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    do_reset();
    st.push_back(mk(0, 0, 0, 0, 1, 0)); ex.push_back('{6'b000000, 6'b000000});
    for (int k = 1; k <= 10; k++) begin
      st.push_back(mk(0, 0, k == 1, k == 2, 0, k == 10));
      ex.push_back('{6'b000011, 6'b000011});
    end
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    st.push_back(mk(0, 0, 0, 0, 0, 1)); ex.push_back('{6'b000000, 6'b000000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (o_a !== e.a) begin errors++; $display("FAIL switch[%0d] dut_a got %b expected %b", i, o_a, e.a); end
      checks++;
      if (o_b !== e.b) begin errors++; $display("FAIL switch[%0d] dut_b got %b expected %b", i, o_b, e.b); end
    end
    checks++;
    if (stall_count_a !== 4'd10 || stall_count_b !== 4'd10 || flush_count_a !== 4'd0 || flush_count_b !== 4'd0) begin
      errors++;
      $display("FAIL switch_counters stall a=%0d b=%0d flush a=%0d b=%0d expected 10/10 0/0",
               stall_count_a, stall_count_b, flush_count_a, flush_count_b);
    end
  endtask

  task automatic test_switch_blocked();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    do_reset();
    st.push_back(mk(1, 0, 0, 0, 1, 0)); ex.push_back('{6'b000010, 6'b000010});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    st.push_back(mk(0, 0, 0, 0, 0, 0)); ex.push_back('{6'b000000, 6'b000000});
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if (o_a !== e.a) begin errors++; $display("FAIL switch_blocked[%0d] dut_a got %b expected %b", i, o_a, e.a); end
      checks++;
      if (o_b !== e.b) begin errors++; $display("FAIL switch_blocked[%0d] dut_b got %b expected %b", i, o_b, e.b); end
    end
  endtask

  task automatic test_reset_in_switch();
    do_reset();
    apply(mk(0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++) apply(mk(0, 0, 0, 0, 0, 0));
    #2;
    checks++;
    if (o_a !== 6'b000011 || stall_count_a !== 4'd2 || stall_count_b !== 4'd2) begin
      errors++;
      $display("FAIL reset_sw_pre out=%b stall a=%0d b=%0d expected 000011 2/2", o_a, stall_count_a, stall_count_b);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (o_a !== 6'b0 || o_b !== 6'b0) begin
      errors++;
      $display("FAIL reset_sw_async a=%b b=%b expected 000000", o_a, o_b);
    end
    checks++;
    if (stall_count_a !== 4'd0 || stall_count_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_sw_counters a=%0d b=%0d expected 0", stall_count_a, stall_count_b);
    end
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0, 0, 1, 0, 0, 0));
    #2;
    checks++;
    if (o_a !== 6'b111000 || o_b !== 6'b111000) begin
      errors++;
      $display("FAIL reset_sw_run a=%b b=%b expected 111000", o_a, o_b);
    end
    apply(mk(0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) apply(mk(1, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0));
    #2;
    checks++;
    if (stall_count_a !== 4'hF || stall_count_b !== 4'hF) begin
      errors++;
      $display("FAIL stall_saturate a=%0d b=%0d expected 15", stall_count_a, stall_count_b);
    end
    for (int k = 0; k < 20; k++) apply(mk(0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) apply(mk(0, 0, 0, 0, 0, 0));
    #2;
    checks++;
    if (flush_count_a !== 4'hF || flush_count_b !== 4'hF) begin
      errors++;
      $display("FAIL flush_saturate a=%0d b=%0d expected 15", flush_count_a, flush_count_b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_busywait_load();
    test_switch();
    test_switch_blocked();
    test_reset_in_switch();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
